// File: rtl/mpu_sample_scheduler.sv
// Purpose: sequences the IMU driver (one-shot init, then a 12-byte burst per sample tick) and publishes six signed words.
// Latency: mpu_transfer is visible two cycles after an accepted tick; words/sample_valid are visible the cycle after the 12th byte strobe.
// Backpressure: busy_now holds the request in REQ, bounded by TIMEOUT_CYC; ticks arriving while not idle are dropped and counted.
module mpu_sample_scheduler #(
  parameter int CLK_MAIN    = 50000000,
  parameter int SAMPLE_HZ   = 1000,
  parameter int N_BYTES     = 12,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               mpu_init,
  input  logic               init_done,
  output logic               mpu_transfer,
  input  logic               busy_now,
  input  logic               data_avalid,
  input  logic [7:0]         data,
  output logic signed [15:0] ax,
  output logic signed [15:0] ay,
  output logic signed [15:0] az,
  output logic signed [15:0] gx,
  output logic signed [15:0] gy,
  output logic signed [15:0] gz,
  output logic               sample_valid,
  output logic               fault,
  output logic [7:0]         overrun_cnt,
  output logic               sample_tick
);

  localparam int PERIOD = CLK_MAIN / SAMPLE_HZ;
  localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]    IDX_LAST  = 4'(N_BYTES - 1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_WAIT_INIT,
    ST_IDLE,
    ST_REQ,
    ST_CAPTURE,
    ST_PUBLISH,
    ST_FAULT
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [TW-1:0]        to_cnt_q, to_cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [7:0]           byte_buf_q [N_BYTES];
  logic [7:0]           byte_buf_d [N_BYTES];
  logic                 mpu_init_q, mpu_init_d;
  logic                 mpu_transfer_q, mpu_transfer_d;
  logic                 sample_valid_q, sample_valid_d;
  logic                 fault_q, fault_d;
  logic [7:0]           overrun_q, overrun_d;
  logic signed [15:0]   ax_q, ay_q, az_q, gx_q, gy_q, gz_q;
  logic signed [15:0]   ax_d, ay_d, az_d, gx_d, gy_d, gz_d;
  logic                 to_hit;

  // The tick is decoded straight from the free-running counter so the FSM and the export see the same cycle.
  assign sample_tick  = (tick_cnt_q == TICK_LAST);
  assign to_hit       = (to_cnt_q == TO_LAST);

  assign mpu_init     = mpu_init_q;
  assign mpu_transfer = mpu_transfer_q;
  assign sample_valid = sample_valid_q;
  assign fault        = fault_q;
  assign overrun_cnt  = overrun_q;
  assign ax = ax_q;
  assign ay = ay_q;
  assign az = az_q;
  assign gx = gx_q;
  assign gy = gy_q;
  assign gz = gz_q;

  // Next-state logic: tick counter, overrun accounting, sequencing FSM and byte capture.
  always_comb begin
    state_d        = state_q;
    tick_cnt_d     = sample_tick ? '0 : tick_cnt_q + 1'b1;
    to_cnt_d       = '0;  // any state change restarts the stall timer
    idx_d          = idx_q;
    byte_buf_d     = byte_buf_q;
    mpu_init_d     = 1'b0;
    mpu_transfer_d = 1'b0;
    sample_valid_d = 1'b0;
    fault_d        = fault_q;
    overrun_d      = overrun_q;
    ax_d = ax_q;
    ay_d = ay_q;
    az_d = az_q;
    gx_d = gx_q;
    gy_d = gy_q;
    gz_d = gz_q;

    // A tick that IDLE cannot accept is lost; count it unless the run is disabled.
    if (sample_tick && enable && (state_q != ST_IDLE) && (overrun_q != 8'hFF))
      overrun_d = overrun_q + 8'd1;

    case (state_q)
      ST_INIT: begin
        mpu_init_d = 1'b1;
        state_d    = ST_WAIT_INIT;
      end
      ST_WAIT_INIT: begin
        if (init_done) begin
          state_d = ST_IDLE;
        end else if (to_hit) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (sample_tick && enable)
          state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!busy_now) begin
          mpu_transfer_d = 1'b1;
          idx_d          = '0;
          state_d        = ST_CAPTURE;
        end else if (to_hit) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (data_avalid) begin
          byte_buf_d[idx_q] = data;
          if (idx_q != IDX_LAST)
            idx_d = idx_q + 4'd1;
        end
        if (data_avalid && (idx_q == IDX_LAST)) begin
          // Words are built from the buffer including the byte arriving now, so sample_valid lines up with PUBLISH.
          ax_d = {byte_buf_d[0],  byte_buf_d[1]};
          ay_d = {byte_buf_d[2],  byte_buf_d[3]};
          az_d = {byte_buf_d[4],  byte_buf_d[5]};
          gx_d = {byte_buf_d[6],  byte_buf_d[7]};
          gy_d = {byte_buf_d[8],  byte_buf_d[9]};
          gz_d = {byte_buf_d[10], byte_buf_d[11]};
          sample_valid_d = 1'b1;
          fault_d        = 1'b0;
          state_d        = ST_PUBLISH;
        end else if (to_hit) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_PUBLISH: state_d = ST_IDLE;
      ST_FAULT:   state_d = ST_INIT;
      default:    state_d = ST_INIT;
    endcase
  end

  // State and registered outputs; synchronous active-low reset clears everything and restarts init.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_INIT;
      tick_cnt_q     <= '0;
      to_cnt_q       <= '0;
      idx_q          <= '0;
      for (int i = 0; i < N_BYTES; i++) byte_buf_q[i] <= '0;
      mpu_init_q     <= 1'b0;
      mpu_transfer_q <= 1'b0;
      sample_valid_q <= 1'b0;
      fault_q        <= 1'b0;
      overrun_q      <= '0;
      ax_q <= '0;
      ay_q <= '0;
      az_q <= '0;
      gx_q <= '0;
      gy_q <= '0;
      gz_q <= '0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      to_cnt_q       <= to_cnt_d;
      idx_q          <= idx_d;
      byte_buf_q     <= byte_buf_d;
      mpu_init_q     <= mpu_init_d;
      mpu_transfer_q <= mpu_transfer_d;
      sample_valid_q <= sample_valid_d;
      fault_q        <= fault_d;
      overrun_q      <= overrun_d;
      ax_q <= ax_d;
      ay_q <= ay_d;
      az_q <= az_d;
      gx_q <= gx_d;
      gy_q <= gy_d;
      gz_q <= gz_d;
    end
  end

endmodule

// File: doc/mpu_sample_scheduler.md
Name: mpu_sample_scheduler

Overview:
- Sequences the I2C IMU driver: issues the one-shot init, then triggers a 12-byte burst read on every sample tick.
- Collects the bytes and publishes six signed 16-bit words with a one-cycle valid strobe for the attitude and PID pipeline.
- Detects stalled transactions and counts sample overruns.
- Sits between the IMU driver (mpu_init / init_done / mpu_transfer / data_avalid / data / busy_now) and the downstream control logic.

Parameters:
- CLK_MAIN, 50000000, system clock frequency in Hz.
- SAMPLE_HZ, 1000, sample tick rate in Hz. PERIOD = CLK_MAIN/SAMPLE_HZ; PERIOD must be at least 2.
- N_BYTES, 12, bytes per burst. Fixed at 12 for the six-word layout.
- TIMEOUT_CYC, 50000, maximum cycles allowed in WAIT_INIT or CAPTURE before a fault is declared.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- enable  in  1  run request. When low, no new bursts start.
- mpu_init  out  1  one-cycle init request to the IMU driver.
- init_done  in  1  driver init complete (level).
- mpu_transfer  out  1  one-cycle burst-read request.
- busy_now  in  1  driver busy.
- data_avalid  in  1  byte strobe from the driver.
- data  in  8  received byte.
- ax, ay, az  out  16 signed  accelerometer words.
- gx, gy, gz  out  16 signed  gyro words.
- sample_valid  out  1  one-cycle pulse when all six words have updated.
- fault  out  1  timeout occurred. Sticky until the next good publish.
- overrun_cnt  out  8  ticks dropped while busy. Saturates at 255.
- sample_tick  out  1  raw tick pulse, exported for dt bookkeeping.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state goes to INIT.
  - All outputs are 0, including the tick counter, byte index, timeout counter and byte buffer.
- Tick generator:
  - Counter runs 0..PERIOD-1 continuously, independent of state.
  - sample_tick is high in the cycle the counter equals PERIOD-1; the counter then wraps to 0.
- INIT: drive mpu_init=1 for exactly one cycle, then go to WAIT_INIT and clear the timeout counter.
- WAIT_INIT:
  - init_done=1 -> IDLE.
  - Timeout counter reaches TIMEOUT_CYC-1 -> FAULT.
- IDLE:
  - If sample_tick and enable are both high -> REQ.
  - enable low: remain in IDLE; ticks are ignored and not counted.
- REQ:
  - busy_now=0: pulse mpu_transfer for one cycle, clear the byte index and timeout counter, go to CAPTURE.
  - busy_now=1: wait in REQ. The timeout counter runs; reaching TIMEOUT_CYC-1 -> FAULT.
- CAPTURE:
  - Each data_avalid stores data into buf[idx], then idx increments.
  - When the byte at idx=11 is stored -> PUBLISH.
  - Timeout counter reaching TIMEOUT_CYC-1 -> FAULT.
- PUBLISH (one cycle):
  - Words are assembled big-endian from buf:
    - ax={buf0,buf1}, ay={buf2,buf3}, az={buf4,buf5}
    - gx={buf6,buf7}, gy={buf8,buf9}, gz={buf10,buf11}
  - Words are registered and update only in this cycle; outputs hold between publishes.
  - sample_valid=1 and fault is cleared in this cycle.
  - Next state -> IDLE.
- FAULT (one cycle): set fault=1, go to INIT, which re-initialises the driver.
- Overrun:
  - A sample_tick with enable=1 while state is not IDLE increments overrun_cnt, saturating at 255.
  - The tick is dropped, not queued.
  - A tick in the same cycle that IDLE accepts it is not an overrun.
- Ignored inputs:
  - data_avalid outside CAPTURE is ignored; idx is unchanged.
  - init_done outside WAIT_INIT is ignored.
- enable deasserted mid-burst: the burst completes and publishes, then the block stays in IDLE.
- Reset mid-burst: immediate return to INIT. Partial bytes are discarded and outputs cleared.
- Reads use N_BYTES=12. No truncation; idx is 4 bits and never exceeds 11.

Test Plan:
- Normal init: CLK_MAIN=1000, SAMPLE_HZ=100 (PERIOD=10), TIMEOUT_CYC=20.
  - Release rst_n -> mpu_init pulses once in the first cycle after reset.
  - Assert init_done after 5 cycles -> IDLE; the first mpu_transfer follows the first sample_tick, at counter=9.
- Data assembly: feed bytes 0x12,0x34,0xFF,0x38,0x40,0x00,0x00,0x01,0x80,0x00,0x7F,0xFF.
  - Expect one sample_valid pulse with ax=0x1234, ay=-200, az=16384, gx=1, gy=-32768, gz=32767.
- Capture timeout: after mpu_transfer, send only 5 bytes -> fault=1 twenty cycles after the transfer, then mpu_init re-pulses.
  - A subsequent good burst clears fault in the sample_valid cycle.
- Overrun: hold busy_now=1 for 25 cycles in REQ -> overrun_cnt increments on each dropped tick.
  - A forced run of 300 drops leaves overrun_cnt at 255.
- Stray bytes and enable: pulse data_avalid while in IDLE -> no state change, no output change.
  - Drop enable during byte 6 -> the burst publishes, and no further mpu_transfer occurs over 50 cycles.
- Reset mid-capture: assert rst_n=0 after byte 4 for one cycle -> all outputs 0, state INIT, mpu_init pulses again.
  - The next burst assembles correctly from byte 0.
